// File: rtl/capture_pkg.sv
// Shared command codes, mode/tx-state encodings and the status byte layout
// for the SPI capture controller.
package capture_pkg;

  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_STOP   = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] CMD_READ   = 8'h04;
  localparam logic [7:0] CMD_CLEAR  = 8'h05;

  typedef enum logic {
    M_CMD,
    M_READ
  } mode_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_FETCH,
    TX_LOAD
  } tx_state_t;

  // Status byte as seen by the SPI master: {full, empty, capture_en, drops[4:0]}
  function automatic logic [7:0] statusByte(input logic full, input logic empty,
                                            input logic cap, input logic [4:0] ovf);
    return {full, empty, cap, ovf};
  endfunction

endpackage

// File: rtl/cs_sync.sv
// Flop synchronizer for the asynchronous chip select with a one-cycle pulse
// on each synchronized rising edge (deselect).
module cs_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_last;

  // Resets to the deselected level so releasing reset never fakes an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_last <= 1'b1;
    end else begin
      r_sync[0] <= i_async;
      for (int k = 1; k < STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_last <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_last;

endmodule

// File: rtl/capture_ctrl.sv
// SPI command controller: decodes command bytes, gates capture, streams FIFO
// bytes back on reads, answers status requests and counts dropped samples.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int         OVF_W          = 5,
  parameter logic [7:0] IDLE_BYTE      = 8'hA5,
  parameter logic [7:0] EMPTY_BYTE     = 8'h00,
  parameter int         CS_SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       spi_rx_data,
  input  logic             spi_rx_valid,
  input  logic             spi_tx_req,
  input  logic             cs,
  output logic [7:0]       spi_tx_data,
  output logic             spi_tx_valid,
  output logic             capture_en,
  output logic             fifo_clear,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_rd_data,
  input  logic             fifo_empty,
  input  logic             fifo_full,
  input  logic             sample_drop,
  output logic [OVF_W-1:0] ovf_count
);

  logic             w_cs_rise;
  mode_t            r_mode;
  tx_state_t        r_tx_state;
  tx_state_t        w_tx_state_next;
  logic             r_capture_en;
  logic             r_status_armed;
  logic             r_fifo_clear;
  logic             r_fifo_rd_en;
  logic             r_tx_valid;
  logic [7:0]       r_tx_data;
  logic [OVF_W-1:0] r_ovf_count;

  logic             w_cmd_valid;
  logic             w_cmd_start;
  logic             w_cmd_stop;
  logic             w_cmd_status;
  logic             w_cmd_read;
  logic             w_cmd_clear;
  logic             w_ovf_sat;
  logic [4:0]       w_ovf5;
  logic [7:0]       w_status_byte;
  logic             w_status_taken;
  logic             w_tx_valid_next;
  logic [7:0]       w_tx_data_next;
  logic             w_rd_en_next;

  cs_sync #(
    .STAGES (CS_SYNC_STAGES)
  ) u_cs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (cs),
    .o_rise  (w_cs_rise)
  );

  assign w_cmd_valid  = spi_rx_valid && (r_mode == M_CMD);
  assign w_cmd_start  = w_cmd_valid && (spi_rx_data == CMD_START);
  assign w_cmd_stop   = w_cmd_valid && (spi_rx_data == CMD_STOP);
  assign w_cmd_status = w_cmd_valid && (spi_rx_data == CMD_STATUS);
  assign w_cmd_read   = w_cmd_valid && (spi_rx_data == CMD_READ);
  assign w_cmd_clear  = w_cmd_valid && (spi_rx_data == CMD_CLEAR);

  // Deselect wins over anything decoded in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode         <= M_CMD;
      r_capture_en   <= 1'b0;
      r_status_armed <= 1'b0;
      r_fifo_clear   <= 1'b0;
    end else begin
      r_fifo_clear <= w_cmd_clear;

      if (w_cs_rise) begin
        r_mode <= M_CMD;
      end else if (w_cmd_read) begin
        r_mode <= M_READ;
      end

      if (w_cmd_start) begin
        r_capture_en <= 1'b1;
      end else if (w_cmd_stop) begin
        r_capture_en <= 1'b0;
      end

      if (w_cs_rise) begin
        r_status_armed <= 1'b0;
      end else if (w_cmd_status) begin
        r_status_armed <= 1'b1;
      end else if (w_status_taken) begin
        r_status_armed <= 1'b0;
      end
    end
  end

  assign w_ovf_sat = &r_ovf_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf_count <= '0;
    end else if (w_cmd_clear) begin
      r_ovf_count <= '0;
    end else if (sample_drop && !w_ovf_sat) begin
      r_ovf_count <= r_ovf_count + OVF_W'(1);
    end
  end

  // Status byte always carries exactly five counter bits
  if (OVF_W >= 5) begin : g_ovf_wide
    assign w_ovf5 = r_ovf_count[4:0];
  end else begin : g_ovf_narrow
    assign w_ovf5 = {{(5-OVF_W){1'b0}}, r_ovf_count};
  end

  assign w_status_byte = statusByte(fifo_full, fifo_empty, r_capture_en, w_ovf5);

  always_comb begin
    w_tx_state_next = r_tx_state;
    w_tx_valid_next = 1'b0;
    w_tx_data_next  = r_tx_data;
    w_rd_en_next    = 1'b0;
    w_status_taken  = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (spi_tx_req) begin
          if (r_status_armed) begin
            w_tx_valid_next = 1'b1;
            w_tx_data_next  = w_status_byte;
            w_status_taken  = 1'b1;
          end else if ((r_mode == M_READ) && !fifo_empty && !r_fifo_clear) begin
            w_rd_en_next    = 1'b1;
            w_tx_state_next = TX_FETCH;
          end else if (r_mode == M_READ) begin
            w_tx_valid_next = 1'b1;
            w_tx_data_next  = EMPTY_BYTE;
          end else begin
            w_tx_valid_next = 1'b1;
            w_tx_data_next  = IDLE_BYTE;
          end
        end
      end
      TX_FETCH: begin
        w_tx_state_next = TX_LOAD;
      end
      TX_LOAD: begin
        w_tx_valid_next = 1'b1;
        w_tx_data_next  = fifo_rd_data;
        w_tx_state_next = TX_IDLE;
      end
      default: begin
        w_tx_state_next = TX_IDLE;
      end
    endcase
  end

  // Reset here also abandons an in-flight fetch, so no late tx_valid escapes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state   <= TX_IDLE;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= IDLE_BYTE;
      r_fifo_rd_en <= 1'b0;
    end else begin
      r_tx_state   <= w_tx_state_next;
      r_tx_valid   <= w_tx_valid_next;
      r_tx_data    <= w_tx_data_next;
      r_fifo_rd_en <= w_rd_en_next;
    end
  end

  assign spi_tx_data  = r_tx_data;
  assign spi_tx_valid = r_tx_valid;
  assign capture_en   = r_capture_en;
  assign fifo_clear   = r_fifo_clear;
  assign fifo_rd_en   = r_fifo_rd_en;
  assign ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: directed vector table, corner-case
// sequences and randomized operations against a transaction-level model.
module tb_capture_ctrl;
  import capture_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] spi_rx_data = 8'h00;
  logic       spi_rx_valid = 1'b0;
  logic       spi_tx_req = 1'b0;
  logic       cs = 1'b0;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_full = 1'b0;
  logic       sample_drop = 1'b0;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       capture_en;
  logic       fifo_clear;
  logic       fifo_rd_en;
  logic [4:0] ovf_count;

  capture_ctrl #(
    .OVF_W          (5),
    .IDLE_BYTE      (8'hA5),
    .EMPTY_BYTE     (8'h00),
    .CS_SYNC_STAGES (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_tx_req   (spi_tx_req),
    .cs           (cs),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_valid (spi_tx_valid),
    .capture_en   (capture_en),
    .fifo_clear   (fifo_clear),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .sample_drop  (sample_drop),
    .ovf_count    (ovf_count)
  );

  always #5 clk = ~clk;

  typedef enum int {OP_CMD, OP_DROP, OP_TXREQ, OP_PUSH, OP_CSUP} op_e;

  typedef struct {
    op_e        op;
    logic [7:0] arg;
    logic [7:0] base;
    logic       expCap;
    logic [4:0] expOvf;
    int         expClr;
    int         expRd;
    logic [7:0] expTx;
    int         expLat;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } txEv_t;

  vec_t       vecs[$];
  txEv_t      txq[$];
  logic [7:0] fq[$];
  logic [7:0] mq[$];
  logic [7:0] holdData = 8'h00;
  logic       holdPending = 1'b0;
  int         cyc = 0;
  int         reqCyc = 0;
  int         rdCnt = 0;
  int         clrCnt = 0;
  int         rdBad = 0;
  int         nCompared = 0;
  int         nMismatched = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor plus external FIFO: read data appears one cycle after the strobe
  always @(negedge clk) begin
    if (spi_tx_valid) txq.push_back('{cyc: cyc, data: spi_tx_data});
    if (fifo_clear) clrCnt++;
    if (fifo_rd_en) rdCnt++;
    if (fifo_rd_en && (fq.size() == 0 || fifo_clear)) rdBad++;
    if (holdPending) begin
      fifo_rd_data = holdData;
      holdPending  = 1'b0;
    end
    if (fifo_clear) begin
      fq.delete();
    end else if (fifo_rd_en && fq.size() > 0) begin
      holdData    = fq.pop_front();
      holdPending = 1'b1;
    end
    fifo_empty = (fq.size() == 0);
    fifo_full  = (fq.size() >= DEPTH);
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tickN(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic startOp();
    txq.delete();
    rdCnt  = 0;
    clrCnt = 0;
  endtask

  task automatic applyStimulus(input op_e op, input logic [7:0] arg, input logic [7:0] base);
    case (op)
      OP_CMD: begin
        spi_rx_data  = arg;
        spi_rx_valid = 1'b1;
        tickN(1);
        spi_rx_valid = 1'b0;
        tickN(2);
      end
      OP_DROP: begin
        for (int i = 0; i < int'(arg); i++) begin
          sample_drop = 1'b1;
          tickN(1);
        end
        sample_drop = 1'b0;
        tickN(1);
      end
      OP_TXREQ: begin
        spi_tx_req = 1'b1;
        reqCyc     = cyc;
        tickN(1);
        spi_tx_req = 1'b0;
        tickN(5);
      end
      OP_PUSH: begin
        for (int i = 0; i < int'(arg); i++) begin
          if (fq.size() < DEPTH) fq.push_back(base + 8'(i * 17));
        end
        tickN(1);
      end
      default: begin
        cs = 1'b1;
        tickN(5);
        cs = 1'b0;
        tickN(3);
      end
    endcase
  endtask

  task automatic checkOp(input string name, input logic cap, input logic [4:0] ovf,
                         input int clr, input int rd);
    checkOutput({name, "_cap"}, capture_en, cap);
    checkOutput({name, "_ovf"}, ovf_count, ovf);
    checkOutput({name, "_clr"}, clrCnt, clr);
    checkOutput({name, "_rd"}, rdCnt, rd);
  endtask

  task automatic checkTx(input string name, input logic [7:0] tx, input int lat);
    checkOutput({name, "_txcount"}, txq.size(), 1);
    if (txq.size() > 0) begin
      checkOutput({name, "_txdata"}, txq[0].data, tx);
      checkOutput({name, "_txlat"}, txq[0].cyc - reqCyc, lat);
    end
  endtask

  task automatic addVec(input op_e op, input logic [7:0] arg, input logic [7:0] base,
                        input logic cap, input logic [4:0] ovf, input int clr, input int rd,
                        input logic [7:0] tx, input int lat);
    vecs.push_back('{op, arg, base, cap, ovf, clr, rd, tx, lat});
  endtask

  initial begin
    logic       mCap;
    logic       mRead;
    logic       mArmed;
    int         mOvf;
    int         r;
    int         n;
    logic [7:0] b;
    logic [7:0] d;
    logic [7:0] eTx;
    int         eLat;
    int         eRd;
    int         eClr;

    //        op        arg    base   cap ovf clr rd tx     lat
    addVec(OP_TXREQ, 8'd0,  8'h00, 0,  0,  0,  0, 8'hA5, 1);
    addVec(OP_CMD,   8'h01, 8'h00, 1,  0,  0,  0, 8'h00, 0);
    addVec(OP_DROP,  8'd3,  8'h00, 1,  3,  0,  0, 8'h00, 0);
    addVec(OP_PUSH,  8'd8,  8'h11, 1,  3,  0,  0, 8'h00, 0);
    addVec(OP_CMD,   8'h03, 8'h00, 1,  3,  0,  0, 8'h00, 0);
    addVec(OP_TXREQ, 8'd0,  8'h00, 1,  3,  0,  0, 8'hA3, 1);
    addVec(OP_TXREQ, 8'd0,  8'h00, 1,  3,  0,  0, 8'hA5, 1);
    addVec(OP_CMD,   8'h05, 8'h00, 1,  0,  1,  0, 8'h00, 0);
    addVec(OP_CMD,   8'h03, 8'h00, 1,  0,  0,  0, 8'h00, 0);
    addVec(OP_TXREQ, 8'd0,  8'h00, 1,  0,  0,  0, 8'h60, 1);
    addVec(OP_PUSH,  8'd2,  8'h11, 1,  0,  0,  0, 8'h00, 0);
    addVec(OP_CMD,   8'h04, 8'h00, 1,  0,  0,  0, 8'h00, 0);
    addVec(OP_TXREQ, 8'd0,  8'h00, 1,  0,  0,  1, 8'h11, 3);
    addVec(OP_TXREQ, 8'd0,  8'h00, 1,  0,  0,  1, 8'h22, 3);
    addVec(OP_TXREQ, 8'd0,  8'h00, 1,  0,  0,  0, 8'h00, 1);
    addVec(OP_CSUP,  8'd0,  8'h00, 1,  0,  0,  0, 8'h00, 0);
    addVec(OP_TXREQ, 8'd0,  8'h00, 1,  0,  0,  0, 8'hA5, 1);
    addVec(OP_CMD,   8'h02, 8'h00, 0,  0,  0,  0, 8'h00, 0);
    addVec(OP_CMD,   8'h04, 8'h00, 0,  0,  0,  0, 8'h00, 0);
    addVec(OP_CMD,   8'h01, 8'h00, 0,  0,  0,  0, 8'h00, 0);
    addVec(OP_TXREQ, 8'd0,  8'h00, 0,  0,  0,  0, 8'h00, 1);
    addVec(OP_CSUP,  8'd0,  8'h00, 0,  0,  0,  0, 8'h00, 0);
    addVec(OP_CMD,   8'h03, 8'h00, 0,  0,  0,  0, 8'h00, 0);
    addVec(OP_CMD,   8'h04, 8'h00, 0,  0,  0,  0, 8'h00, 0);
    addVec(OP_TXREQ, 8'd0,  8'h00, 0,  0,  0,  0, 8'h40, 1);
    addVec(OP_TXREQ, 8'd0,  8'h00, 0,  0,  0,  0, 8'h00, 1);
    addVec(OP_CSUP,  8'd0,  8'h00, 0,  0,  0,  0, 8'h00, 0);
    addVec(OP_CMD,   8'h07, 8'h00, 0,  0,  0,  0, 8'h00, 0);
    addVec(OP_TXREQ, 8'd0,  8'h00, 0,  0,  0,  0, 8'hA5, 1);

    rst_n = 1'b0;
    tickN(3);
    checkOutput("reset_tx_data", spi_tx_data, 8'hA5);
    checkOutput("reset_tx_valid", spi_tx_valid, 1'b0);
    checkOutput("reset_cap", capture_en, 1'b0);
    checkOutput("reset_ovf", ovf_count, 5'd0);
    checkOutput("reset_clr", fifo_clear, 1'b0);
    checkOutput("reset_rd", fifo_rd_en, 1'b0);
    rst_n = 1'b1;
    tickN(2);

    for (int i = 0; i < vecs.size(); i++) begin
      startOp();
      applyStimulus(vecs[i].op, vecs[i].arg, vecs[i].base);
      checkOp($sformatf("vec%0d", i), vecs[i].expCap, vecs[i].expOvf, vecs[i].expClr, vecs[i].expRd);
      if (vecs[i].op == OP_TXREQ) checkTx($sformatf("vec%0d", i), vecs[i].expTx, vecs[i].expLat);
    end

    // Saturation, then CLEAR racing a drop in the same cycle
    startOp();
    applyStimulus(OP_DROP, 8'd40, 8'h00);
    checkOutput("sat_ovf", ovf_count, 5'd31);
    spi_rx_data  = CMD_CLEAR;
    spi_rx_valid = 1'b1;
    sample_drop  = 1'b1;
    tickN(1);
    spi_rx_valid = 1'b0;
    sample_drop  = 1'b0;
    checkOutput("clr_race_ovf", ovf_count, 5'd0);
    checkOutput("clr_race_pulse", fifo_clear, 1'b1);
    tickN(1);
    checkOutput("clr_race_pulse_end", fifo_clear, 1'b0);
    applyStimulus(OP_DROP, 8'd1, 8'h00);
    checkOutput("ovf_resume", ovf_count, 5'd1);

    // READ and tx_req in the same cycle: READ only applies to the next request
    applyStimulus(OP_PUSH, 8'd1, 8'h5C);
    startOp();
    spi_rx_data  = CMD_READ;
    spi_rx_valid = 1'b1;
    spi_tx_req   = 1'b1;
    reqCyc       = cyc;
    tickN(1);
    spi_rx_valid = 1'b0;
    spi_tx_req   = 1'b0;
    tickN(5);
    checkTx("read_same_cycle", 8'hA5, 1);
    checkOutput("read_same_cycle_rd", rdCnt, 0);
    startOp();
    applyStimulus(OP_TXREQ, 8'd0, 8'h00);
    checkTx("read_after", 8'h5C, 3);
    checkOutput("read_after_rd", rdCnt, 1);
    applyStimulus(OP_CSUP, 8'd0, 8'h00);

    // Reset while a fetch is in flight
    applyStimulus(OP_CMD, CMD_START, 8'h00);
    applyStimulus(OP_DROP, 8'd2, 8'h00);
    applyStimulus(OP_PUSH, 8'd1, 8'h77);
    applyStimulus(OP_CMD, CMD_READ, 8'h00);
    startOp();
    spi_tx_req = 1'b1;
    tickN(1);
    spi_tx_req = 1'b0;
    checkOutput("fetch_rd_en", fifo_rd_en, 1'b1);
    rst_n = 1'b0;
    tickN(1);
    checkOutput("midrst_tx_valid", spi_tx_valid, 1'b0);
    checkOutput("midrst_tx_data", spi_tx_data, 8'hA5);
    checkOutput("midrst_cap", capture_en, 1'b0);
    checkOutput("midrst_ovf", ovf_count, 5'd0);
    checkOutput("midrst_clr", fifo_clear, 1'b0);
    checkOutput("midrst_rd", fifo_rd_en, 1'b0);
    rst_n = 1'b1;
    tickN(6);
    checkOutput("midrst_no_tx", txq.size(), 0);

    // Randomized operations against a transaction-level model
    applyStimulus(OP_CMD, CMD_CLEAR, 8'h00);
    mq.delete();
    mCap   = 1'b0;
    mRead  = 1'b0;
    mArmed = 1'b0;
    mOvf   = 0;
    for (int k = 0; k < 200; k++) begin
      r    = $urandom_range(0, 99);
      eRd  = 0;
      eClr = 0;
      startOp();
      if (r < 30) begin
        n = $urandom_range(0, 9);
        b = (n <= 5) ? 8'(n) : 8'($urandom);
        if (!mRead) begin
          case (b)
            8'h01: mCap = 1'b1;
            8'h02: mCap = 1'b0;
            8'h03: mArmed = 1'b1;
            8'h04: mRead = 1'b1;
            8'h05: begin
              mOvf = 0;
              mq.delete();
              eClr = 1;
            end
            default: ;
          endcase
        end
        applyStimulus(OP_CMD, b, 8'h00);
      end else if (r < 45) begin
        n    = $urandom_range(1, 12);
        mOvf = (mOvf + n > 31) ? 31 : mOvf + n;
        applyStimulus(OP_DROP, 8'(n), 8'h00);
      end else if (r < 75) begin
        eLat = 1;
        if (mArmed) begin
          eTx    = {mq.size() >= DEPTH, mq.size() == 0, mCap, 5'(mOvf)};
          mArmed = 1'b0;
        end else if (mRead && mq.size() > 0) begin
          eTx  = mq.pop_front();
          eLat = 3;
          eRd  = 1;
        end else if (mRead) begin
          eTx = 8'h00;
        end else begin
          eTx = 8'hA5;
        end
        applyStimulus(OP_TXREQ, 8'd0, 8'h00);
        checkTx($sformatf("rnd%0d", k), eTx, eLat);
      end else if (r < 90) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          if (mq.size() < DEPTH) begin
            d = 8'($urandom);
            mq.push_back(d);
            fq.push_back(d);
          end
        end
        tickN(1);
      end else begin
        mRead  = 1'b0;
        mArmed = 1'b0;
        applyStimulus(OP_CSUP, 8'd0, 8'h00);
      end
      checkOp($sformatf("rnd%0d", k), mCap, 5'(mOvf), eClr, eRd);
    end

    checkOutput("rd_en_while_empty_or_clear", rdBad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
